// File: rtl/regfile_scoreboard.sv
// Register file with write-to-read bypass and a busy scoreboard.
// Issue logic reserves registers; write-back clears them.
module regfile_scoreboard #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  output logic [ADDR_W:0]   busy_count,
  output logic              wr_unrsv
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W:0]   cnt_nxt;
  logic              wr_ok;
  logic              rsv_ok;
  logic              hit1;
  logic              hit2;

  // Register 0 swallows writes and reserves when hardwired to zero.
  always_comb begin
    wr_ok  = wr_en;
    rsv_ok = rsv_en;
    if (ZERO_REG != 0) begin
      if (wr_addr == '0)
        wr_ok = 1'b0;
      if (rsv_addr == '0)
        rsv_ok = 1'b0;
    end
  end

  // Next busy vector: write clears, reserve sets and wins on a tie.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok)
      busy_nxt[wr_addr] = 1'b0;
    if (rsv_ok)
      busy_nxt[rsv_addr] = 1'b1;
    if (reset)
      busy_nxt = '0;
  end

  // Population count of the next busy vector.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
  end

  // Array, scoreboard and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      busy       <= '0;
      busy_count <= '0;
      wr_unrsv   <= 1'b0;
    end else begin
      if (wr_ok)
        mem[wr_addr] <= wr_data;
      busy       <= busy_nxt;
      busy_count <= cnt_nxt;
      wr_unrsv   <= wr_ok && !busy[wr_addr];
    end
  end

  // A pending write to the addressed register is forwarded.
  always_comb begin
    hit1 = (BYPASS != 0) && wr_ok && !reset
           && (wr_addr == rd_addr1);
    hit2 = (BYPASS != 0) && wr_ok && !reset
           && (wr_addr == rd_addr2);
  end

  // Read ports.
  always_comb begin
    rd_data1 = hit1 ? wr_data : mem[rd_addr1];
    rd_data2 = hit2 ? wr_data : mem[rd_addr2];
    rd_busy1 = hit1 ? 1'b0 : busy[rd_addr1];
    rd_busy2 = hit2 ? 1'b0 : busy[rd_addr2];
  end

endmodule
